ram_responder: RTL and testbench

- Memory-side end of the CPU/RAM word interface. Drives the `ramstate` handshake (FREE/BUSY/ACCESS/ERROR) consumed by CPU-side initiators such as the datapath and ALU test harness.
- Holds a word-addressed storage array and answers reads and writes after a programmable latency.
- Provides a side-band debug read port so benches can dump stored results without using the handshake.

---
 rtl/ram_responder_pkg.sv | 22 ++
 rtl/ram_latency_ctr.sv | 67 ++++++
 rtl/ram_responder.sv | 67 ++++++
 tb/tb_ram_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the CPU/RAM word interface and the RAM responder.
//   word_t     : 32-bit bus word
//   ramstate_t : handshake state seen by CPU-side initiators
//   RAM_FILL   : value on ramload whenever no read data is being returned
package ram_responder_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned ADDR_LSB   = $clog2(WORD_BYTES);

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   localparam word_t RAM_FILL = 32'hBAD1BAD1;

endpackage

// File: rtl/ram_latency_ctr.sv
// Request change detection, latency counter and ramstate decode.
//   CLK, nRST        : clock, async active-low reset
//   ramaddr          : byte address of the current request
//   ramREN, ramWEN   : read / write request
//   ramstate         : combinational FREE/BUSY/ACCESS/ERROR
module ram_latency_ctr
   import ram_responder_pkg::*;
#(
   parameter int unsigned LAT   = 2,
   parameter int unsigned DEPTH = 256
) (
   input  logic      CLK,
   input  logic      nRST,
   input  word_t     ramaddr,
   input  logic      ramREN,
   input  logic      ramWEN,
   output ramstate_t ramstate
);

   localparam int unsigned CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_eff;
   logic          prev_valid;
   word_t         prev_addr;
   logic          prev_ren;
   logic          prev_wen;
   logic          req;
   logic          bad;
   logic          changed;

   // Classify the request and decode the handshake state
   always_comb begin
      req     = ramREN | ramWEN;
      bad     = (ramREN & ramWEN)
              | (ramaddr[ADDR_LSB-1:0] != '0)
              | ((ramaddr >> ADDR_LSB) >= WORD_W'(DEPTH));
      // Write data is deliberately excluded: only address/type restart the count
      changed = !prev_valid | (ramaddr != prev_addr)
              | (ramREN != prev_ren) | (ramWEN != prev_wen);
      cnt_eff = changed ? '0 : cnt;
      ramstate = FREE;
      if (req) begin
         if (bad)                      ramstate = ERROR;
         else if (cnt_eff == CW'(LAT)) ramstate = ACCESS;
         else                          ramstate = BUSY;
      end
   end

   // Request history and latency count; count only advances while BUSY
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt        <= '0;
         prev_valid <= 1'b0;
         prev_addr  <= '0;
         prev_ren   <= 1'b0;
         prev_wen   <= 1'b0;
      end else begin
         prev_valid <= req & ~bad;
         prev_addr  <= ramaddr;
         prev_ren   <= ramREN;
         prev_wen   <= ramWEN;
         cnt        <= (ramstate == BUSY) ? cnt_eff + CW'(1) : '0;
      end
   end

endmodule

// File: rtl/ram_responder.sv
// Memory-side end of the CPU/RAM word interface with programmable latency.
//   CLK, nRST         : clock, async active-low reset (clears all storage)
//   ramaddr, ramstore : request byte address and write data
//   ramREN, ramWEN    : read / write request
//   ramload           : read data during ACCESS with ramREN, FILL otherwise
//   ramstate          : combinational handshake state
//   dbg_addr/dbg_data : side-band combinational read, 0 when out of range
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter int unsigned LAT   = 2,
   parameter int unsigned DEPTH = 256,
   parameter word_t       FILL  = RAM_FILL
) (
   input  logic      CLK,
   input  logic      nRST,
   input  word_t     ramaddr,
   input  word_t     ramstore,
   input  logic      ramREN,
   input  logic      ramWEN,
   output word_t     ramload,
   output ramstate_t ramstate,
   input  word_t     dbg_addr,
   output word_t     dbg_data
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   word_t     mem [DEPTH];
   ramstate_t state_c;
   word_t     req_idx;
   word_t     dbg_idx;

   ram_latency_ctr #(
      .LAT   (LAT),
      .DEPTH (DEPTH)
   ) u_ctr (
      .CLK      (CLK),
      .nRST     (nRST),
      .ramaddr  (ramaddr),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramstate (state_c)
   );

   assign ramstate = state_c;
   assign req_idx  = ramaddr >> ADDR_LSB;
   assign dbg_idx  = dbg_addr >> ADDR_LSB;

   // Storage; a write commits on the edge closing its ACCESS cycle
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if ((state_c == ACCESS) && ramWEN) begin
         mem[AW'(req_idx)] <= ramstore;
      end
   end

   // Handshake read data and debug read mux
   always_comb begin
      ramload  = FILL;
      dbg_data = '0;
      if ((state_c == ACCESS) && ramREN) ramload = mem[AW'(req_idx)];
      if (dbg_idx < WORD_W'(DEPTH))      dbg_data = mem[AW'(dbg_idx)];
   end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LAT=2, LAT=0 and LAT=3.
module tb_ram_responder;
   import ram_responder_pkg::*;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   word_t a2, s2, l2, da2, dd2;  logic r2, w2;  ramstate_t st2;
   word_t a0, s0, l0, da0, dd0;  logic r0, w0;  ramstate_t st0;
   word_t a3, s3, l3, da3, dd3;  logic r3, w3;  ramstate_t st3;

   ram_responder #(.LAT(2), .DEPTH(256)) u_lat2 (
      .CLK(CLK), .nRST(nRST), .ramaddr(a2), .ramstore(s2), .ramREN(r2), .ramWEN(w2),
      .ramload(l2), .ramstate(st2), .dbg_addr(da2), .dbg_data(dd2));
   ram_responder #(.LAT(0), .DEPTH(256)) u_lat0 (
      .CLK(CLK), .nRST(nRST), .ramaddr(a0), .ramstore(s0), .ramREN(r0), .ramWEN(w0),
      .ramload(l0), .ramstate(st0), .dbg_addr(da0), .dbg_data(dd0));
   ram_responder #(.LAT(3), .DEPTH(256)) u_lat3 (
      .CLK(CLK), .nRST(nRST), .ramaddr(a3), .ramstore(s3), .ramREN(r3), .ramWEN(w3),
      .ramload(l3), .ramstate(st3), .dbg_addr(da3), .dbg_data(dd3));

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge, where inputs are driven
   task automatic next_cyc();
      @(posedge CLK);
      #1;
   endtask

   localparam word_t FILLV = 32'hBAD1BAD1;

   initial begin
      nRST = 1'b0;
      {a2, s2, da2, r2, w2} = '0;
      {a0, s0, da0, r0, w0} = '0;
      {a3, s3, da3, r3, w3} = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_eq("rst_state", 32'(st2), 32'(FREE));
      check_eq("rst_load",  l2, FILLV);
      check_eq("rst_dbg",   dd2, 32'h0);
      nRST = 1'b1;
      next_cyc();

      // LAT=2 write 0x14: BUSY, BUSY, ACCESS
      a2 = 32'h14; s2 = 32'hDEADBEEF; w2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check_eq($sformatf("wr14_st%0d", i), 32'(st2), (i < 2) ? 32'(BUSY) : 32'(ACCESS));
         next_cyc();
      end
      w2 = 1'b0;
      da2 = 32'h14; #1;
      check_eq("wr14_dbg", dd2, 32'hDEADBEEF);

      // LAT=2 read 0x14: FILL, FILL, data
      r2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check_eq($sformatf("rd14_st%0d", i), 32'(st2), (i < 2) ? 32'(BUSY) : 32'(ACCESS));
         check_eq($sformatf("rd14_ld%0d", i), l2, (i < 2) ? FILLV : 32'hDEADBEEF);
         next_cyc();
      end
      r2 = 1'b0;
      @(negedge CLK);
      check_eq("idle_free", 32'(st2), 32'(FREE));
      check_eq("idle_load", l2, FILLV);
      da2 = 32'h400; #1;
      check_eq("dbg_oob", dd2, 32'h0);
      next_cyc();

      // LAT=0 back-to-back writes 0x00..0x3C plus top word 0x3FC
      w0 = 1'b1;
      for (int k = 0; k < 17; k++) begin
         a0 = (k < 16) ? 32'(k * 4) : 32'h3FC;
         s0 = 32'hA5000000 + 32'(k * 32'h00010101);
         @(negedge CLK);
         check_eq($sformatf("b2b_st%0d", k), 32'(st0), 32'(ACCESS));
         next_cyc();
      end
      w0 = 1'b0;
      for (int k = 0; k < 17; k++) begin
         da0 = (k < 16) ? 32'(k * 4) : 32'h3FC;
         #1;
         check_eq($sformatf("b2b_dbg%0d", k), dd0, 32'hA5000000 + 32'(k * 32'h00010101));
      end

      // LAT=3: 2 BUSY at 0x08, switch to 0x0C, 3 BUSY, ACCESS
      a3 = 32'h08; s3 = 32'h11111111; w3 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) a3 = 32'h0C;
         @(negedge CLK);
         check_eq($sformatf("chg_st%0d", i), 32'(st3), (i < 5) ? 32'(BUSY) : 32'(ACCESS));
         next_cyc();
      end
      w3 = 1'b0;
      da3 = 32'h08; #1;
      check_eq("chg_dbg08", dd3, 32'h0);
      da3 = 32'h0C; #1;
      check_eq("chg_dbg0c", dd3, 32'h11111111);

      // ERROR cases on LAT=2: both enables, misaligned, out of range
      s2 = 32'h55555555;
      for (int c = 0; c < 3; c++) begin
         r2 = (c == 0);
         w2 = 1'b1;
         a2 = (c == 0) ? 32'h18 : (c == 1) ? 32'h402 : 32'h400;
         for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_eq($sformatf("err%0d_st%0d", c, i), 32'(st2), 32'(ERROR));
            check_eq($sformatf("err%0d_ld%0d", c, i), l2, FILLV);
            next_cyc();
         end
      end
      r2 = 1'b0; w2 = 1'b0;
      da2 = 32'h18; #1;
      check_eq("err_dbg18", dd2, 32'h0);
      da2 = 32'h14; #1;
      check_eq("err_dbg14", dd2, 32'hDEADBEEF);
      da2 = 32'h00; #1;
      check_eq("err_dbg00", dd2, 32'h0);

      // Reset during 2nd BUSY of a write to 0x20
      a2 = 32'h20; s2 = 32'hCAFEF00D; w2 = 1'b1;
      @(negedge CLK);
      check_eq("rb_st0", 32'(st2), 32'(BUSY));
      next_cyc();
      @(negedge CLK);
      check_eq("rb_st1", 32'(st2), 32'(BUSY));
      nRST = 1'b0;
      da2 = 32'h14; #1;
      check_eq("rb_cleared14", dd2, 32'h0);
      da0 = 32'h04; #1;
      check_eq("rb_cleared_lat0", dd0, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      da2 = 32'h20; #1;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("ra_st%0d", i), 32'(st2), (i < 2) ? 32'(BUSY) : 32'(ACCESS));
         check_eq($sformatf("ra_dbg%0d", i), dd2, 32'h0);
         next_cyc();
         @(negedge CLK);
      end
      w2 = 1'b0; #1;
      check_eq("ra_commit", dd2, 32'hCAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
